// File: rtl/conv_pool_seq.sv
// Frame sequencer for conv_pool: holds kernels/shift, streams one frame of
// block addresses and tracks per-channel result counts to detect done/stall/overrun.
module conv_pool_seq #(
   parameter int ADDR_W        = 16,
   parameter int NUM_BLOCKS    = 65536,
   parameter int OUT_COUNT     = 65536,
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              cfg_we_i,
   input  logic [1:0]        cfg_sel_i,
   input  logic [71:0]       cfg_data_i,
   output logic [71:0]       conv_kernel_0_o,
   output logic [71:0]       conv_kernel_1_o,
   output logic [71:0]       conv_kernel_2_o,
   output logic [1:0]        shift_o,
   output logic              input_re_o,
   output logic [ADDR_W-1:0] input_addr_o,
   input  logic              output_we_0_i,
   input  logic              output_we_1_i,
   input  logic              output_we_2_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_code_o
);

   localparam int CW = $clog2(OUT_COUNT + 1);
   localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BLOCKS - 1);
   localparam logic [CW-1:0]     FULL      = CW'(OUT_COUNT);
   localparam logic [TW-1:0]     TMO_MAX   = TW'(DRAIN_TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE, S_ERR} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [2:0][CW-1:0]  cnt_q, cnt_d;
   logic [TW-1:0]       tmo_q, tmo_d, tmo_inc;
   logic                err_q, err_d;
   logic [1:0]          code_q, code_d;
   logic [2:0][71:0]    kern_q, kern_d;
   logic [1:0]          shift_q, shift_d;
   logic [2:0]          we;
   logic                counting, overrun, all_full;

   assign we       = {output_we_2_i, output_we_1_i, output_we_0_i};
   assign counting = (state_q == S_LOAD) || (state_q == S_DRAIN);
   assign tmo_inc  = tmo_q + 1'b1;

   always_comb begin
      overrun  = 1'b0;
      all_full = 1'b1;
      cnt_d    = cnt_q;
      for (int k = 0; k < 3; k++) begin
         if (cnt_q[k] != FULL) all_full = 1'b0;
         // a strobe on an already-full channel saturates and flags overrun
         if (counting && we[k]) begin
            if (cnt_q[k] == FULL) overrun = 1'b1;
            else                  cnt_d[k] = cnt_q[k] + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      code_d  = code_q;
      kern_d  = kern_q;
      shift_d = shift_q;
      case (state_q)
         S_IDLE: begin
            if (cfg_we_i) begin
               if (cfg_sel_i == 2'd3) shift_d = cfg_data_i[1:0];
               else                   kern_d[cfg_sel_i] = cfg_data_i;
            end
            if (start_i && !abort_i) begin
               addr_d  = '0;
               tmo_d   = '0;
               err_d   = 1'b0;
               code_d  = 2'd0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (overrun) begin
               state_d = S_ERR;
               err_d   = 1'b1;
               code_d  = 2'd2;
            end else if (addr_q == LAST_ADDR) begin
               state_d = S_DRAIN;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (overrun) begin
               state_d = S_ERR;
               err_d   = 1'b1;
               code_d  = 2'd2;
            end else if (all_full) begin
               state_d = S_DONE;
            end else if (|we) begin
               tmo_d = '0;
            end else if (tmo_inc == TMO_MAX) begin
               tmo_d   = tmo_inc;
               state_d = S_ERR;
               err_d   = 1'b1;
               code_d  = 2'd1;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
      if (abort_i) state_d = S_IDLE;
   end

   // counters are cleared only on the start edge; abort keeps them
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         code_q  <= 2'd0;
         kern_q  <= '0;
         shift_q <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= (state_q == S_IDLE && start_i && !abort_i) ? '0 : cnt_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         code_q  <= code_d;
         kern_q  <= kern_d;
         shift_q <= shift_d;
      end
   end

   assign conv_kernel_0_o = kern_q[0];
   assign conv_kernel_1_o = kern_q[1];
   assign conv_kernel_2_o = kern_q[2];
   assign shift_o         = shift_q;
   assign input_re_o      = (state_q == S_LOAD);
   assign input_addr_o    = addr_q;
   assign busy_o          = counting;
   assign done_o          = (state_q == S_DONE);
   assign err_o           = err_q;
   assign err_code_o      = code_q;

endmodule

// File: tb/tb_conv_pool_seq.sv
// Directed bench for conv_pool_seq: table-driven config/frame pass plus
// hand-written overrun, timeout, abort and async-reset sequences.
module tb_conv_pool_seq;

   localparam int AW = 4;
   localparam logic [71:0] K0  = 72'h010203040506070809;
   localparam logic [71:0] K1X = 72'hA5A5A5A5A5A5A5A5A5;

   logic        clk, rst_n, start, abort, cfg_we;
   logic [1:0]  cfg_sel;
   logic [71:0] cfg_data;
   logic [71:0] k0, k1, k2;
   logic [1:0]  shift, err_code;
   logic        re, busy, done, err;
   logic [AW-1:0] addr;
   logic [2:0]  we;

   int n_cmp = 0;
   int n_err = 0;
   logic saw_done;

   conv_pool_seq #(.ADDR_W(AW), .NUM_BLOCKS(8), .OUT_COUNT(2), .DRAIN_TIMEOUT(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_data_i(cfg_data),
      .conv_kernel_0_o(k0), .conv_kernel_1_o(k1), .conv_kernel_2_o(k2),
      .shift_o(shift), .input_re_o(re), .input_addr_o(addr),
      .output_we_0_i(we[0]), .output_we_1_i(we[1]), .output_we_2_i(we[2]),
      .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic st, ab, cw; logic [1:0] sel; logic [71:0] d; logic [2:0] w;
      logic re; logic [AW-1:0] addr; logic busy, done, err; logic [1:0] code;
      logic [71:0] k0, k1; logic [1:0] sh;
   } vec_t;

   function automatic vec_t mk(logic st, logic cw, logic [1:0] sel, logic [71:0] d,
                               logic [2:0] w, logic e_re, logic [AW-1:0] e_addr,
                               logic e_busy, logic e_done, logic [71:0] e_k0, logic [1:0] e_sh);
      vec_t v;
      v.st = st; v.ab = 1'b0; v.cw = cw; v.sel = sel; v.d = d; v.w = w;
      v.re = e_re; v.addr = e_addr; v.busy = e_busy; v.done = e_done;
      v.err = 1'b0; v.code = 2'd0; v.k0 = e_k0; v.k1 = '0; v.sh = e_sh;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic st, input logic ab, input logic cw, input logic [1:0] sel,
                       input logic [71:0] d, input logic [2:0] w);
      @(negedge clk);
      start = st; abort = ab; cfg_we = cw; cfg_sel = sel; cfg_data = d; we = w;
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, '0, 3'b000);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " k0"}, k0, '0);
      chk({tag, " k1"}, k1, '0);
      chk({tag, " k2"}, k2, '0);
      chk({tag, " shift"}, {70'd0, shift}, '0);
      chk({tag, " re"}, {71'd0, re}, '0);
      chk({tag, " addr"}, {{(72-AW){1'b0}}, addr}, '0);
      chk({tag, " busy"}, {71'd0, busy}, '0);
      chk({tag, " done"}, {71'd0, done}, '0);
      chk({tag, " err"}, {71'd0, err}, '0);
      chk({tag, " err_code"}, {70'd0, err_code}, '0);
   endtask

   vec_t tbl[16];

   initial begin
      rst_n = 1'b0; start = 0; abort = 0; cfg_we = 0; cfg_sel = 0; cfg_data = '0; we = '0;
      saw_done = 1'b0;
      //        st cw sel  data  we      re addr busy done k0  sh
      tbl[0]  = mk(0, 1, 2'd0, K0,    3'b000, 0, 0, 0, 0, K0, 2'd0);
      tbl[1]  = mk(0, 1, 2'd3, 72'h2, 3'b000, 0, 0, 0, 0, K0, 2'd2);
      tbl[2]  = mk(1, 0, 2'd0, '0,    3'b000, 1, 0, 1, 0, K0, 2'd2);
      tbl[3]  = mk(0, 0, 2'd0, '0,    3'b000, 1, 1, 1, 0, K0, 2'd2);
      tbl[4]  = mk(1, 1, 2'd1, K1X,   3'b000, 1, 2, 1, 0, K0, 2'd2);
      tbl[5]  = mk(0, 1, 2'd1, K1X,   3'b000, 1, 3, 1, 0, K0, 2'd2);
      tbl[6]  = mk(0, 0, 2'd0, '0,    3'b000, 1, 4, 1, 0, K0, 2'd2);
      tbl[7]  = mk(0, 0, 2'd0, '0,    3'b000, 1, 5, 1, 0, K0, 2'd2);
      tbl[8]  = mk(0, 0, 2'd0, '0,    3'b000, 1, 6, 1, 0, K0, 2'd2);
      tbl[9]  = mk(0, 0, 2'd0, '0,    3'b000, 1, 7, 1, 0, K0, 2'd2);
      tbl[10] = mk(0, 0, 2'd0, '0,    3'b000, 0, 7, 1, 0, K0, 2'd2);
      tbl[11] = mk(0, 0, 2'd0, '0,    3'b111, 0, 7, 1, 0, K0, 2'd2);
      tbl[12] = mk(0, 0, 2'd0, '0,    3'b111, 0, 7, 1, 0, K0, 2'd2);
      tbl[13] = mk(0, 0, 2'd0, '0,    3'b000, 0, 7, 0, 1, K0, 2'd2);
      tbl[14] = mk(0, 0, 2'd0, '0,    3'b111, 0, 7, 0, 0, K0, 2'd2);
      tbl[15] = mk(0, 0, 2'd0, '0,    3'b111, 0, 7, 0, 0, K0, 2'd2);

      repeat (2) @(posedge clk);
      #1 chk_reset_vals("reset");
      @(negedge clk) rst_n = 1'b1;

      // config then frame, with config/start attempts during LOAD
      for (int i = 0; i < 16; i++) begin
         step(tbl[i].st, tbl[i].ab, tbl[i].cw, tbl[i].sel, tbl[i].d, tbl[i].w);
         chk($sformatf("row%0d re", i),   {71'd0, re}, {71'd0, tbl[i].re});
         chk($sformatf("row%0d addr", i), {{(72-AW){1'b0}}, addr}, {{(72-AW){1'b0}}, tbl[i].addr});
         chk($sformatf("row%0d busy", i), {71'd0, busy}, {71'd0, tbl[i].busy});
         chk($sformatf("row%0d done", i), {71'd0, done}, {71'd0, tbl[i].done});
         chk($sformatf("row%0d err", i),  {71'd0, err}, {71'd0, tbl[i].err});
         chk($sformatf("row%0d code", i), {70'd0, err_code}, {70'd0, tbl[i].code});
         chk($sformatf("row%0d k0", i),   k0, tbl[i].k0);
         chk($sformatf("row%0d k1", i),   k1, tbl[i].k1);
         chk($sformatf("row%0d shift", i), {70'd0, shift}, {70'd0, tbl[i].sh});
      end

      // simultaneous strobes then overrun on channel 1
      saw_done = 1'b0;
      step(1, 0, 0, 2'd0, '0, 3'b000);
      idle(8);
      chk("ovr in drain", {71'd0, busy & ~re}, 72'd1);
      step(0, 0, 0, 2'd0, '0, 3'b111);
      step(0, 0, 0, 2'd0, '0, 3'b111);
      step(0, 0, 0, 2'd0, '0, 3'b010);
      chk("ovr err", {71'd0, err}, 72'd1);
      chk("ovr code", {70'd0, err_code}, 72'd2);
      chk("ovr busy", {71'd0, busy}, 72'd0);
      step(1, 0, 0, 2'd0, '0, 3'b000);
      chk("ovr err held", {71'd0, err}, 72'd1);
      chk("ovr start ignored", {71'd0, re}, 72'd0);
      chk("ovr no done", {71'd0, saw_done}, 72'd0);
      step(0, 1, 0, 2'd0, '0, 3'b000);
      chk("ovr abort err", {71'd0, err}, 72'd1);
      chk("ovr abort code", {70'd0, err_code}, 72'd2);

      // drain timeout: channel 2 short by one result
      step(1, 0, 0, 2'd0, '0, 3'b000);
      chk("tmo start clears err", {71'd0, err}, 72'd0);
      chk("tmo start clears code", {70'd0, err_code}, 72'd0);
      chk("tmo start re", {71'd0, re}, 72'd1);
      idle(8);
      step(0, 0, 0, 2'd0, '0, 3'b111);
      step(0, 0, 0, 2'd0, '0, 3'b011);
      for (int i = 1; i <= 3; i++) begin
         idle(1);
         chk($sformatf("tmo wait%0d err", i), {71'd0, err}, 72'd0);
         chk($sformatf("tmo wait%0d busy", i), {71'd0, busy}, 72'd1);
      end
      idle(1);
      chk("tmo err", {71'd0, err}, 72'd1);
      chk("tmo code", {70'd0, err_code}, 72'd1);
      chk("tmo busy", {71'd0, busy}, 72'd0);
      step(0, 1, 0, 2'd0, '0, 3'b000);
      chk("tmo abort err kept", {71'd0, err}, 72'd1);
      chk("tmo abort code kept", {70'd0, err_code}, 72'd1);
      step(1, 0, 0, 2'd0, '0, 3'b000);
      chk("tmo restart err", {71'd0, err}, 72'd0);
      chk("tmo restart busy", {71'd0, busy}, 72'd1);

      // abort mid-LOAD after counting results; restart must begin clean
      step(0, 0, 0, 2'd0, '0, 3'b111);
      step(0, 0, 0, 2'd0, '0, 3'b111);
      step(0, 0, 0, 2'd0, '0, 3'b000);
      chk("abt at addr3", {{(72-AW){1'b0}}, addr}, 72'd3);
      step(0, 1, 0, 2'd0, '0, 3'b000);
      chk("abt re", {71'd0, re}, 72'd0);
      chk("abt busy", {71'd0, busy}, 72'd0);
      idle(1);
      chk("abt idle", {71'd0, busy | re}, 72'd0);
      step(1, 0, 0, 2'd0, '0, 3'b000);
      chk("abt restart addr", {{(72-AW){1'b0}}, addr}, 72'd0);
      chk("abt restart re", {71'd0, re}, 72'd1);
      idle(8);
      saw_done = 1'b0;
      step(0, 0, 0, 2'd0, '0, 3'b111);
      step(0, 0, 0, 2'd0, '0, 3'b111);
      idle(1);
      chk("abt frame done", {71'd0, done}, 72'd1);
      chk("abt frame err", {71'd0, err}, 72'd0);
      idle(1);
      chk("abt done pulse", {71'd0, done}, 72'd0);

      // async reset between edges, mid-DRAIN and mid-LOAD
      step(1, 0, 0, 2'd0, '0, 3'b000);
      idle(8);
      step(0, 0, 0, 2'd0, '0, 3'b111);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("arst drain");
      @(negedge clk) rst_n = 1'b1;
      step(1, 0, 0, 2'd0, '0, 3'b000);
      idle(2);
      chk("arst load re before", {71'd0, re}, 72'd1);
      #2 rst_n = 1'b0;
      #1 chk("arst load re", {71'd0, re}, 72'd0);
      chk("arst load addr", {{(72-AW){1'b0}}, addr}, 72'd0);
      @(negedge clk) rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
